rotfpga_scan_ctrl: RTL

ROTFPGA_SCAN_CTRL -- requirements
Module: rotfpga_scan_ctrl

---
 rtl/rotfpga_scan_ctrl.sv | 71 +++++++
 1 files changed

// File: rtl/rotfpga_scan_ctrl.sv
// rotfpga_scan_ctrl: multi-lane config scan chain with frame-aligned commit; ROTFPGA_SCAN_CRC_EN adds lane-0 CRC-8 gating
module rotfpga_scan_ctrl #(
  parameter int LANES = 2,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_se,
  input  logic [LANES-1:0]       in_sc,
  input  logic                   in_commit,
  output logic [LANES-1:0]       out_sc,
  output logic [LANES*DEPTH-1:0] cfg,
  output logic                   frame_done,
  output logic                   commit_err,
  output logic [7:0]             crc
);
  localparam int CW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state_q, state_d;
  logic [LANES-1:0][DEPTH-1:0] chain_q, chain_d, cfg_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fd_q, err_q, err_d, wrap, accept, crc_ok;
`ifdef ROTFPGA_SCAN_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic fb;
  // bit-serial CRC-8 (poly 0x07, MSB-first) over lane 0, cleared when a frame is committed
  always_comb begin
    fb = crc_q[7] ^ in_sc[0];
    crc_d = accept ? 8'h00 : in_se ? ({crc_q[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00)) : crc_q;
  end
  // CRC register
  always_ff @(posedge clk) crc_q <= rst ? 8'h00 : crc_d;
  assign crc_ok = (crc_q == 8'h00);
  assign crc = crc_q;
`else
  assign crc_ok = 1'b1;
  assign crc = 8'h00;
`endif
  // chain shift, bit counter, commit acceptance and control state selection
  always_comb begin
    for (int k = 0; k < LANES; k++) chain_d[k] = in_se ? {chain_q[k][DEPTH-2:0], in_sc[k]} : chain_q[k];
    wrap = in_se && (cnt_q == CW'(DEPTH - 1));
    cnt_d = in_se ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
    accept = in_commit && !in_se && (state_q != SHIFT) && crc_ok;
    err_d = accept ? 1'b0 : (in_commit ? 1'b1 : err_q);
    state_d = accept ? COMMIT : ((cnt_d != '0) ? SHIFT : IDLE);
  end
  // control state register
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  // datapath registers; cfg loads only on an accepted commit
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      cfg_q <= '0;
      cnt_q <= '0;
      fd_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      chain_q <= chain_d;
      cfg_q <= accept ? chain_q : cfg_q;
      cnt_q <= cnt_d;
      fd_q <= wrap;
      err_q <= err_d;
    end
  end
  // serial outputs are the chain MSBs
  always_comb for (int k = 0; k < LANES; k++) out_sc[k] = chain_q[k][DEPTH-1];
  assign cfg = cfg_q;
  assign frame_done = fd_q;
  assign commit_err = err_q;
endmodule
